// File: rtl/intc_pkg.sv
// Shared types for the prioritised interrupt controller: FSM state encoding
// and the vector-address helper.
package intc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SERV = 2'd2
   } state_t;

   // The caller keeps only the low VEC_W bits, which gives modulo-2^VEC_W wrap.
   function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                            input logic [31:0] stride,
                                            input logic [31:0] idx);
      return base + idx * stride;
   endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder: vld flags any set request bit, and idx
// is the position of the lowest set bit.
module prio_enc #(
   parameter int N  = 4,
   parameter int IW = 3
) (
   input  logic [N-1:0]  req,
   output logic          vld,
   output logic [IW-1:0] idx
);

   always_comb begin
      vld = 1'b0;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            vld = 1'b1;
            idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/intc_prio.sv
// Prioritised interrupt controller: edge-captured pending bits, masking,
// fixed-priority grant and in-service tracking. Preemption by a
// higher-priority channel is enabled when INTC_NESTING_EN is defined.
module intc_prio
   import intc_pkg::*;
#(
   parameter int               N_IRQ      = 4,
   parameter int               VEC_W      = 10,
   parameter logic [VEC_W-1:0] VEC_BASE   = 10'b1101100000,
   parameter int               VEC_STRIDE = 8,
   parameter int               ID_W       = $clog2(N_IRQ + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IRQ-1:0] irq,
   input  logic [N_IRQ-1:0] mask,
   input  logic             e_interrupt,
   input  logic             ack,
   input  logic             iret,
   output logic [ID_W-1:0]  ir_attended,
   output logic [VEC_W-1:0] dir_sal_in,
   output logic [N_IRQ-1:0] in_service
);

`ifdef INTC_NESTING_EN
   localparam bit NEST = 1'b1;
`else
   localparam bit NEST = 1'b0;
`endif

   state_t           state;
   logic [N_IRQ-1:0] irq_q;
   logic [N_IRQ-1:0] pending;
   logic [ID_W-1:0]  gnt;

   logic [N_IRQ-1:0] cand;
   logic             c_vld;
   logic [ID_W-1:0]  c_idx;
   logic             s_vld;
   logic [ID_W-1:0]  s_idx;
   logic [N_IRQ-1:0] gnt_oh;
   logic [N_IRQ-1:0] s_oh;
   logic [N_IRQ-1:0] clr;
   logic [31:0]      vec_full;
   logic             preempt;

   assign cand = pending & mask & {N_IRQ{e_interrupt}};

   prio_enc #(.N(N_IRQ), .IW(ID_W)) u_cand_enc (
      .req (cand),
      .vld (c_vld),
      .idx (c_idx)
   );

   prio_enc #(.N(N_IRQ), .IW(ID_W)) u_serv_enc (
      .req (in_service),
      .vld (s_vld),
      .idx (s_idx)
   );

   assign gnt_oh   = N_IRQ'(1) << gnt;
   assign s_oh     = N_IRQ'(1) << s_idx;
   assign clr      = (state == REQ && ack) ? gnt_oh : '0;
   assign vec_full = vec_addr(32'(VEC_BASE), 32'(VEC_STRIDE), 32'(c_idx));
   // Only a strictly higher-priority channel may interrupt a running handler.
   assign preempt  = NEST && c_vld && (c_idx < s_idx);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         irq_q       <= '0;
         pending     <= '0;
         in_service  <= '0;
         gnt         <= '0;
         ir_attended <= '0;
         dir_sal_in  <= '0;
      end else begin
         irq_q   <= irq;
         // A fresh edge on the channel being acknowledged stays pending.
         pending <= (pending & ~clr) | (irq & ~irq_q);
         case (state)
            IDLE: begin
               if (c_vld) begin
                  state       <= REQ;
                  gnt         <= c_idx;
                  ir_attended <= c_idx + ID_W'(1);
                  dir_sal_in  <= VEC_W'(vec_full);
               end
            end
            REQ: begin
               if (ack) begin
                  state       <= SERV;
                  in_service  <= in_service | gnt_oh;
                  ir_attended <= '0;
                  dir_sal_in  <= '0;
               end else if (!e_interrupt || !(|(mask & gnt_oh))) begin
                  state       <= (NEST && |in_service) ? SERV : IDLE;
                  ir_attended <= '0;
                  dir_sal_in  <= '0;
               end
            end
            SERV: begin
               if (iret && s_vld) begin
                  in_service <= in_service & ~s_oh;
                  state      <= (NEST && |(in_service & ~s_oh)) ? SERV : IDLE;
               end else if (preempt) begin
                  state       <= REQ;
                  gnt         <= c_idx;
                  ir_attended <= c_idx + ID_W'(1);
                  dir_sal_in  <= VEC_W'(vec_full);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_intc_prio.sv
// Self-checking bench for intc_prio: a cycle table of directed scenarios, a
// reset-mid-request sequence, and randomized traffic against a reference model.
module tb_intc_prio;

   localparam int N  = 4;
   localparam int VW = 10;
   localparam int IW = 3;
   localparam int M_IDLE = 0, M_REQ = 1, M_SERV = 2;
`ifdef INTC_NESTING_EN
   localparam bit NEST = 1'b1;
`else
   localparam bit NEST = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  irq, mask;
   logic          e_interrupt, ack, iret;
   logic [IW-1:0] ir_attended, w_ia;
   logic [VW-1:0] dir_sal_in, w_dir;
   logic [N-1:0]  in_service, w_isv;

   always #5 clk = ~clk;

   intc_prio dut (
      .clk(clk), .reset(reset), .irq(irq), .mask(mask),
      .e_interrupt(e_interrupt), .ack(ack), .iret(iret),
      .ir_attended(ir_attended), .dir_sal_in(dir_sal_in), .in_service(in_service)
   );

   // Base near the top of the address space so channel vectors wrap.
   intc_prio #(.VEC_BASE(10'd1016)) u_wrap (
      .clk(clk), .reset(reset), .irq(irq), .mask(mask),
      .e_interrupt(e_interrupt), .ack(ack), .iret(iret),
      .ir_attended(w_ia), .dir_sal_in(w_dir), .in_service(w_isv)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic [N-1:0]  irq;
      logic [N-1:0]  mask;
      logic          e;
      logic          ack;
      logic          iret;
      logic [IW-1:0] ia;
      logic [VW-1:0] dir;
      logic [N-1:0]  isv;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [N-1:0] i, input logic [N-1:0] m, input logic e,
                      input logic a, input logic r, input int ia, input int dir,
                      input logic [N-1:0] isv);
      vec_t v;
      v.irq = i; v.mask = m; v.e = e; v.ack = a; v.iret = r;
      v.ia = IW'(ia); v.dir = VW'(dir); v.isv = isv;
      tbl.push_back(v);
   endtask

   // Reference model state
   logic [N-1:0] m_irq_q, m_pend, m_isv;
   int m_mode, m_gnt, m_ia, m_dir, m_wdir;

   task automatic m_reset();
      m_irq_q = '0; m_pend = '0; m_isv = '0;
      m_mode = M_IDLE; m_gnt = 0; m_ia = 0; m_dir = 0; m_wdir = 0;
   endtask

   task automatic m_grant(input int c);
      m_mode = M_REQ; m_gnt = c; m_ia = c + 1;
      m_dir  = (864 + c * 8) % 1024;
      m_wdir = (1016 + c * 8) % 1024;
   endtask

   task automatic m_idle_out();
      m_ia = 0; m_dir = 0; m_wdir = 0;
   endtask

   task automatic m_step(input logic [N-1:0] irq_i, input logic [N-1:0] mask_i,
                         input logic e_i, input logic ack_i, input logic iret_i);
      int cand, top;
      logic [N-1:0] np;
      cand = -1; top = -1;
      for (int i = N - 1; i >= 0; i--) begin
         if (m_pend[i] && mask_i[i] && e_i) cand = i;
         if (m_isv[i]) top = i;
      end
      for (int i = 0; i < N; i++)
         np[i] = (irq_i[i] && !m_irq_q[i]) ||
                 (m_pend[i] && !(m_mode == M_REQ && ack_i && m_gnt == i));
      case (m_mode)
         M_IDLE: if (cand >= 0) m_grant(cand);
         M_REQ: begin
            if (ack_i) begin
               m_isv[m_gnt] = 1'b1; m_mode = M_SERV; m_idle_out();
            end else if (!e_i || !mask_i[m_gnt]) begin
               m_idle_out();
               m_mode = (NEST && top >= 0) ? M_SERV : M_IDLE;
            end
         end
         default: begin
            if (iret_i && top >= 0) begin
               m_isv[top] = 1'b0;
               m_mode = (NEST && m_isv != 0) ? M_SERV : M_IDLE;
            end else if (NEST && cand >= 0 && cand < top) begin
               m_grant(cand);
            end
         end
      endcase
      m_pend  = np;
      m_irq_q = irq_i;
   endtask

   initial begin
      reset = 1'b1; irq = '0; mask = 4'b1111; e_interrupt = 1'b1; ack = 1'b0; iret = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ia", 32'(ir_attended), 0);
      chk("reset_dir", 32'(dir_sal_in), 0);
      chk("reset_isv", 32'(in_service), 0);
      reset = 1'b0;

      //   irq      mask     e  ack iret  ia  dir  isv
      add(4'b0001, 4'hF, 1, 0, 0, 0, 0,   4'b0000);
      add(4'b0001, 4'hF, 1, 0, 0, 1, 864, 4'b0000);
      add(4'b0000, 4'hF, 1, 1, 0, 0, 0,   4'b0001);
      add(4'b0000, 4'hF, 1, 0, 1, 0, 0,   4'b0000);
      add(4'b0110, 4'hF, 1, 0, 0, 0, 0,   4'b0000);
      add(4'b0110, 4'hF, 1, 0, 0, 2, 872, 4'b0000);
      add(4'b0000, 4'hF, 1, 1, 0, 0, 0,   4'b0010);
      add(4'b0000, 4'hF, 1, 0, 0, 0, 0,   4'b0010);
      add(4'b0000, 4'hF, 1, 0, 1, 0, 0,   4'b0000);
      add(4'b0000, 4'hF, 1, 0, 0, 3, 880, 4'b0000);
      add(4'b0000, 4'hF, 1, 1, 0, 0, 0,   4'b0100);
      add(4'b0000, 4'hF, 1, 0, 1, 0, 0,   4'b0000);
      add(4'b1000, 4'hF, 1, 0, 0, 0, 0,   4'b0000);
      add(4'b1000, 4'hF, 1, 0, 0, 4, 888, 4'b0000);
      add(4'b0000, 4'hF, 0, 0, 0, 0, 0,   4'b0000);
      add(4'b0000, 4'hF, 0, 0, 0, 0, 0,   4'b0000);
      add(4'b0000, 4'hF, 1, 0, 0, 4, 888, 4'b0000);
      add(4'b0000, 4'hF, 1, 1, 0, 0, 0,   4'b1000);
      add(4'b0000, 4'hF, 1, 0, 1, 0, 0,   4'b0000);
      add(4'b0010, 4'hF, 1, 0, 0, 0, 0,   4'b0000);
      add(4'b0000, 4'hF, 1, 0, 0, 2, 872, 4'b0000);
      add(4'b0000, 4'hD, 1, 0, 0, 0, 0,   4'b0000);
      add(4'b0000, 4'hF, 1, 0, 0, 2, 872, 4'b0000);
      add(4'b0010, 4'hF, 1, 1, 0, 0, 0,   4'b0010);
      add(4'b0000, 4'hF, 1, 0, 0, 0, 0,   4'b0010);
      add(4'b0000, 4'hF, 1, 0, 1, 0, 0,   4'b0000);
      add(4'b0000, 4'hF, 1, 0, 0, 2, 872, 4'b0000);
      add(4'b0000, 4'hF, 1, 1, 0, 0, 0,   4'b0010);
      add(4'b0000, 4'hF, 1, 1, 0, 0, 0,   4'b0010);
      add(4'b0000, 4'hF, 1, 0, 1, 0, 0,   4'b0000);
      add(4'b0000, 4'hF, 1, 0, 1, 0, 0,   4'b0000);
      add(4'b0100, 4'hF, 1, 0, 0, 0, 0,   4'b0000);
      add(4'b0000, 4'hF, 1, 0, 0, 3, 880, 4'b0000);
      add(4'b0000, 4'hF, 1, 1, 0, 0, 0,   4'b0100);
      add(4'b0001, 4'hF, 1, 0, 0, 0, 0,   4'b0100);
      add(4'b0000, 4'hF, 1, 0, 0, NEST ? 1 : 0, NEST ? 864 : 0, 4'b0100);
      add(4'b0000, 4'hF, 1, 1, 0, 0, 0, NEST ? 4'b0101 : 4'b0100);
      add(4'b0000, 4'hF, 1, 0, 1, 0, 0, NEST ? 4'b0100 : 4'b0000);
      add(4'b0000, 4'hF, 1, 0, 0, NEST ? 0 : 1, NEST ? 0 : 864, NEST ? 4'b0100 : 4'b0000);
      add(4'b0000, 4'hF, 1, 1, 0, 0, 0, NEST ? 4'b0100 : 4'b0001);
      add(4'b0000, 4'hF, 1, 0, 1, 0, 0,   4'b0000);

      foreach (tbl[k]) begin
         irq = tbl[k].irq; mask = tbl[k].mask; e_interrupt = tbl[k].e;
         ack = tbl[k].ack; iret = tbl[k].iret;
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_ia", k),  32'(ir_attended), 32'(tbl[k].ia));
         chk($sformatf("tbl%0d_dir", k), 32'(dir_sal_in),  32'(tbl[k].dir));
         chk($sformatf("tbl%0d_isv", k), 32'(in_service),  32'(tbl[k].isv));
      end

      // Reset asserted while a request is on the outputs clears them at once.
      irq = 4'b1000; ack = 1'b0; iret = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("pre_reset_ia", 32'(ir_attended), 4);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_ia", 32'(ir_attended), 0);
      chk("async_reset_dir", 32'(dir_sal_in), 0);
      chk("async_reset_isv", 32'(in_service), 0);
      irq = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_reset();

      for (int c = 0; c < 3000; c++) begin
         irq         = 4'($urandom & $urandom);
         mask        = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
         e_interrupt = ($urandom_range(0, 19) != 0);
         ack         = ($urandom_range(0, 2) == 0);
         iret        = ($urandom_range(0, 3) == 0);
         m_step(irq, mask, e_interrupt, ack, iret);
         @(posedge clk);
         #1;
         chk($sformatf("rnd%0d_ia", c),   32'(ir_attended), 32'(m_ia));
         chk($sformatf("rnd%0d_dir", c),  32'(dir_sal_in),  32'(m_dir));
         chk($sformatf("rnd%0d_isv", c),  32'(in_service),  32'(m_isv));
         chk($sformatf("rnd%0d_wdir", c), 32'(w_dir),       32'(m_wdir));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
